// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg
// Shared definitions for the mux_scan_seq block:
//   - state_t       : sequencer states (IDLE, MANUAL, SCAN)
//   - next_ch_t     : result of an enabled-channel search (found flag + index)
//   - next_enabled(): lowest enabled channel index >= a start point
//   - *_DEF         : default parameter values for the top level
package mux_scan_pkg;

  localparam int N_CH_DEF  = 16;
  localparam int DW_DEF    = 1;
  localparam int DWELL_DEF = 4;
  // Upper bound on N_CH; masks are widened to this size before searching.
  localparam int MAX_CH    = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

  typedef struct packed {
    logic       found;
    logic [7:0] idx;
  } next_ch_t;

  // Lowest channel i with from <= i < n_ch and mask[i] set. The search runs
  // in plain integer arithmetic, so "from" may equal n_ch (no wrap to 0):
  // that is how the end of a sweep is detected.
  function automatic next_ch_t next_enabled(input logic [MAX_CH-1:0] mask,
                                            input int from,
                                            input int n_ch);
    next_ch_t r;
    r.found = 1'b0;
    r.idx   = 8'd0;
    // Walk downwards so the lowest qualifying index is the one left behind.
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (i >= from && i < n_ch && mask[i]) begin
        r.found = 1'b1;
        r.idx   = 8'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_nto1.sv
// mux_nto1
// Purely combinational N_CH x DW selector.
// Ports:
//   w   in  N_CH*DW  packed channels, channel k at w[k*DW +: DW]
//   sel in  SW       channel index
//   y   out DW       selected channel; zero when sel >= N_CH
module mux_nto1 #(
  parameter int N_CH = mux_scan_pkg::N_CH_DEF,
  parameter int DW   = mux_scan_pkg::DW_DEF,
  parameter int SW   = $clog2(N_CH)
) (
  input  logic [N_CH*DW-1:0] w,
  input  logic [SW-1:0]      sel,
  output logic [DW-1:0]      y
);

  logic [DW-1:0] slice [N_CH];

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_slice
    assign slice[gi] = w[gi*DW +: DW];
  end

  // Compare against every legal index instead of indexing the array with
  // sel directly, so an out-of-range select cleanly yields zero.
  always_comb begin
    y = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel == SW'(k)) y = slice[k];
    end
  end

endmodule

// File: rtl/mux_scan_seq.sv
// mux_scan_seq
// Registered N-channel multiplexer with a channel-scan sequencer.
//   Manual mode (mode=0): forwards w[s] every cycle.
//   Scan mode  (mode=1): a start pulse walks channel 0..N_CH-1, each held
//   DWELL cycles, sampled on the first cycle of its dwell; done pulses when
//   the sweep completes, and cont=1 restarts the sweep without a gap.
// Optional build macro MUX_SCAN_MASK_EN adds ch_mask: channels whose mask
// bit is 0 are skipped in zero cycles.
// Ports:
//   Clock    in   rising-edge clock
//   Resetn   in   asynchronous active-low reset
//   w        in   N_CH*DW packed channel data
//   s        in   manual channel select
//   mode     in   0 = manual, 1 = scan
//   start    in   sweep start pulse (honoured only in IDLE with mode=1)
//   cont     in   restart the sweep automatically after the last channel
//   ch_mask  in   per-channel scan enable (MUX_SCAN_MASK_EN only)
//   f        out  registered selected data
//   ch       out  channel index f was taken from
//   f_valid  out  f/ch updated this cycle
//   busy     out  sweep in progress (state SCAN)
//   done     out  one-cycle sweep-complete pulse
//   sel_err  out  manual select out of range
module mux_scan_seq #(
  parameter int N_CH  = mux_scan_pkg::N_CH_DEF,
  parameter int DW    = mux_scan_pkg::DW_DEF,
  parameter int SW    = $clog2(N_CH),
  parameter int DWELL = mux_scan_pkg::DWELL_DEF
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic [N_CH*DW-1:0] w,
  input  logic [SW-1:0]     s,
  input  logic              mode,
  input  logic              start,
  input  logic              cont,
`ifdef MUX_SCAN_MASK_EN
  input  logic [N_CH-1:0]   ch_mask,
`endif
  output logic [DW-1:0]     f,
  output logic [SW-1:0]     ch,
  output logic              f_valid,
  output logic              busy,
  output logic              done,
  output logic              sel_err
);

  import mux_scan_pkg::*;

  localparam int              CW       = $clog2(DWELL + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic              empty_reg, empty_next;
  logic [SW-1:0]     ch_next;
  logic [DW-1:0]     f_next;
  logic              sample;
  logic              done_next;
  logic              sel_err_next;
  logic              s_ok;
  logic [SW-1:0]     mux_sel;
  logic [DW-1:0]     mux_y;
  logic [MAX_CH-1:0] mask_full;
  next_ch_t          first_ch, step_ch;

  always_comb begin
    mask_full = '0;
`ifdef MUX_SCAN_MASK_EN
    mask_full[N_CH-1:0] = ch_mask;
`else
    mask_full[N_CH-1:0] = '1;
`endif
  end

  // first_ch: where a (re)started sweep begins.
  // step_ch : the channel after the current one; not found = sweep over.
  always_comb begin
    first_ch = next_enabled(mask_full, 0, N_CH);
    step_ch  = next_enabled(mask_full, int'(ch) + 1, N_CH);
  end

  assign s_ok = (int'(s) < N_CH);

  // Everything is computed as the value for the coming cycle, so the
  // registered outputs line up with the state they describe: a sample shows
  // up in the first dwell cycle of its channel, and on a cont wrap the
  // channel-0 sample lands in the same cycle as done.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    empty_next   = 1'b0;
    ch_next      = ch;
    sample       = 1'b0;
    done_next    = 1'b0;
    sel_err_next = 1'b0;

    case (state_reg)
      IDLE: begin
        // mode=0 takes priority over a coincident start.
        if (!mode) begin
          state_next = MANUAL;
        end else if (start) begin
          state_next = SCAN;
          cnt_next   = '0;
          if (first_ch.found) begin
            ch_next = SW'(first_ch.idx);
            sample  = 1'b1;
          end else begin
            // Nothing enabled: spend one SCAN cycle, then report done.
            ch_next    = '0;
            empty_next = 1'b1;
          end
        end
      end

      MANUAL: begin
        if (mode) state_next = IDLE;
      end

      SCAN: begin
        if (!mode) begin
          state_next = IDLE;               // abort, no done pulse
        end else if (empty_reg) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          cnt_next = '0;
          if (step_ch.found) begin
            ch_next = SW'(step_ch.idx);
            sample  = 1'b1;
          end else begin
            done_next = 1'b1;
            // An empty mask at wrap time ends the sweep rather than
            // producing a done pulse on every cycle.
            if (cont && first_ch.found) begin
              ch_next = SW'(first_ch.idx);
              sample  = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Manual forwarding applies on every cycle spent in MANUAL, including
    // the one entered from IDLE.
    if (state_next == MANUAL) begin
      if (s_ok) begin
        ch_next = s;
        sample  = 1'b1;
      end else begin
        sel_err_next = 1'b1;
      end
    end
  end

  assign mux_sel = (state_next == MANUAL) ? s : ch_next;

  mux_nto1 #(
    .N_CH (N_CH),
    .DW   (DW),
    .SW   (SW)
  ) u_mux (
    .w   (w),
    .sel (mux_sel),
    .y   (mux_y)
  );

  assign f_next = sample ? mux_y : f;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      empty_reg <= 1'b0;
      f         <= '0;
      ch        <= '0;
      f_valid   <= 1'b0;
      done      <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      empty_reg <= empty_next;
      f         <= f_next;
      ch        <= ch_next;
      f_valid   <= sample;
      done      <= done_next;
      sel_err   <= sel_err_next;
    end
  end

  assign busy = (state_reg == SCAN);

endmodule
